serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that sequences a single instance of the team's 1-bit `full_adder` cell (ports A, B, C, S, Cout).
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Uses a start/ready/done handshake.
- Serves as the area-minimal adder for control paths where latency is unimportant; it is the first block that reuses the cell sequentially rather than replicating it.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while ready=1.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- ready  output  1  high only in IDLE (combinational decode of state).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out; held with sum.

Behaviour:
- States and transitions:
  - IDLE: if start=1 at an edge, go to RUN.
  - RUN: stays for exactly WIDTH edges.
  - DONE: lasts one cycle, then returns to IDLE unconditionally.
- Accept (edge k, IDLE, start=1):
  - Load shift registers sa<=a, sb<=b.
  - Load carry register c<=cin; clear bit counter cnt<=0.
  - Clear internal sum shift register ss.
- Cell connections: A=sa[0], B=sb[0], C=c.
- RUN edge (k+1 .. k+WIDTH):
  - sa and sb shift right by 1.
  - ss shifts right with S entering at MSB.
  - c<=Cout; cnt<=cnt+1.
- On the edge where cnt reaches WIDTH-1 (edge k+WIDTH):
  - sum<={S, ss[WIDTH-1:1]} (final bit included) and cout<=Cout.
  - Go to DONE.
- DONE: done=1 for exactly one cycle.
  - done becomes visible after edge k+WIDTH and drops after edge k+WIDTH+1.
- Latency and throughput:
  - Latency from accepting edge to done high: WIDTH edges.
  - Minimum start-to-start period: WIDTH+2 cycles.
- Result is exact modular arithmetic: {cout,sum} = a + b + cin, computed over WIDTH+1 bits.
- sum and cout do not change during RUN; they update only at completion.
- start while busy or in DONE: ignored, no queuing, operands not recaptured.
- Operand inputs a, b and cin may change freely after the accepting edge.
- start held high continuously: a new operation is accepted on every IDLE edge (back-to-back at WIDTH+2 period).
- Counter width is clog2(WIDTH+1). WIDTH=1 must work (RUN lasts a single edge).
- Reset (rst_n=0, any time, including mid-RUN):
  - Immediately: state=IDLE, sum=0, cout=0, done=0, busy=0, ready=1.
  - All internal registers are 0; any in-flight operation is discarded with no done pulse.
- Deassertion of rst_n is synchronous to the bench; the first accept is possible on the first edge after release.

Test Plan:
- WIDTH=8, a=0x3C, b=0x42, cin=0:
  - busy high for 8 cycles, done pulse 8 edges after the accepting edge.
  - sum=0x7E, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0: sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1: sum=0x00, cout=1.
- WIDTH=8 ignored start: assert start with a=0x11, b=0x22 during RUN of 0x3C+0x42.
  - Result still 0x7E, cout=0.
  - Exactly one done pulse; ready low throughout.
- WIDTH=8 reset abort: drive rst_n low 4 cycles into RUN.
  - Outputs go to sum=0, cout=0, done=0, ready=1 asynchronously (before the next edge).
  - After release, 0x80+0x80 cin=0 gives sum=0x00, cout=1.
- WIDTH=8 back-to-back: start held high with operands 0x01+0x01, then 0x7F+0x01.
  - done pulses exactly 10 cycles apart.
  - Results 0x02/0 and 0x80/0.
- WIDTH=1 exhaustive: all 8 combinations of a, b, cin.
  - {cout,sum} matches the full-adder truth table (e.g. 1,1,1 gives cout=1, sum=1).
  - done 1 edge after each accept.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Start/ready/done handshake and operand/result bus
// for the bit-serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/full_adder.sv
// 1-bit full adder cell.
// Sequenced one bit per clock by serial_adder_ctrl.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ C;
  assign Cout = (A & B) | (C & (A ^ B));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell reused
// LSB first, one bit per clock.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_ss_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  logic             w_acc;
  logic             w_last;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_unused;

  full_adder u_fa (
    .A    (r_sa[0]),
    .B    (r_sb[0]),
    .C    (r_c),
    .S    (w_s),
    .Cout (w_co)
  );

  assign w_acc  = (r_state == S_IDLE) && bus.start;
  assign w_last = (r_state == S_RUN) &&
                  (r_cnt == CW'(WIDTH - 1));

  // bit 0 of ss is always shifted out unused
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_ss_nxt = w_s;
    end else begin : g_wn
      assign w_ss_nxt = {w_s, r_ss[WIDTH-1:1]};
    end
  endgenerate
  assign w_unused = r_ss[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) w_next = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_ss   <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_acc) begin
      r_sa  <= bus.a;
      r_sb  <= bus.b;
      r_c   <= bus.cin;
      r_cnt <= '0;
      r_ss  <= '0;
    end else if (r_state == S_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_ss  <= w_ss_nxt;
      r_c   <= w_co;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_ss_nxt;
        r_cout <= w_co;
      end
    end
  end

  assign bus.ready = w_ready;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;
endmodule
